pipe_ctrl: RTL and testbench

Pipeline control sequencer between fetch, decode and execute. It consumes per-instruction decode results and the execute-stage redirect, then drives fetch stall, IF/ID and ID/IX flushes, and PC redirect. It handles load-use interlocks, illegal-op exceptions with EPC capture, return-from-exception, and halt drain. It is one instance, beside `decode`.

---
 rtl/pipe_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control sequencer between fetch, decode and execute.
//               Generates fetch stall, IF/ID and ID/IX flushes and PC
//               redirects for execute redirects, load-use interlocks,
//               illegal-op exceptions (with EPC capture), return from
//               exception and the HALT drain sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter logic [15:0] EXC_VECTOR   = 16'h0002,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_idix_p1,
  input  logic [15:0] pc_p1,
  input  logic [2:0]  rs_idix_p1,
  input  logic [2:0]  rt_idix_p1,
  input  logic        rs_used_idix_p1,
  input  logic        rt_used_idix_p1,
  input  logic [2:0]  rd_idix_p1,
  input  logic        ld_idix_p1,
  input  logic        halt_idif_p1,
  input  logic        illegal_op_idif_p1,
  input  logic        return_execution_idif_p1,
  input  logic        redirect_ix_p1,
  input  logic [15:0] redirect_target_ix_p1,
  output logic        stall_ifid_p1,
  output logic        flush_ifid_p1,
  output logic        flush_idix_p1,
  output logic        redirect_valid_p1,
  output logic [15:0] redirect_pc_p1,
  output logic [15:0] epc_p1,
  output logic        halted_p1
);

  localparam int             c_CW       = $clog2(DRAIN_CYCLES + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DRAIN_CYCLES - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic              r_ld_pend_v;
  logic              w_ld_pend_v_nxt;
  logic [2:0]        r_ld_pend_rd;
  logic              r_exc_active;
  logic              w_exc_active_nxt;
  logic [15:0]       r_epc;
  logic [15:0]       w_epc_nxt;

  logic              w_hazard;
  logic              w_stall;
  logic              w_flush_ifid;
  logic              w_flush_idix;
  logic              w_redirect;
  logic [15:0]       w_redirect_pc;

  // A source register that is actually read matches the load issued last cycle
  assign w_hazard = r_ld_pend_v &&
                    ((rs_used_idix_p1 && (rs_idix_p1 == r_ld_pend_rd)) ||
                     (rt_used_idix_p1 && (rt_idix_p1 == r_ld_pend_rd)));

  // Next-state and control decode: execute redirect > load-use > decode event
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_ld_pend_v_nxt  = 1'b0;
    w_exc_active_nxt = r_exc_active;
    w_epc_nxt        = r_epc;
    w_stall          = 1'b0;
    w_flush_ifid     = 1'b0;
    w_flush_idix     = 1'b0;
    w_redirect       = 1'b0;
    w_redirect_pc    = 16'h0000;
    case (r_state)
      S_RUN: begin
        if (redirect_ix_p1) begin
          w_redirect    = 1'b1;
          w_redirect_pc = redirect_target_ix_p1;
          w_flush_ifid  = 1'b1;
          w_flush_idix  = 1'b1;
        end else if (inst_valid_idix_p1 && w_hazard) begin
          w_stall      = 1'b1;
          w_flush_idix = 1'b1;
        end else if (inst_valid_idix_p1) begin
          if (illegal_op_idif_p1 && !r_exc_active) begin
            w_redirect       = 1'b1;
            w_redirect_pc    = EXC_VECTOR;
            w_flush_ifid     = 1'b1;
            w_flush_idix     = 1'b1;
            w_epc_nxt        = pc_p1 + 16'd2;
            w_exc_active_nxt = 1'b1;
          end else if (illegal_op_idif_p1 || (halt_idif_p1 && !return_execution_idif_p1)) begin
            // Nested exception is fatal and behaves exactly like HALT
            w_flush_ifid = 1'b1;
            w_state_nxt  = S_DRAIN;
            w_cnt_nxt    = '0;
          end else if (return_execution_idif_p1) begin
            w_redirect       = 1'b1;
            w_redirect_pc    = r_epc;
            w_flush_ifid     = 1'b1;
            w_flush_idix     = 1'b1;
            w_exc_active_nxt = 1'b0;
          end else begin
            w_ld_pend_v_nxt = ld_idix_p1;
          end
        end
      end
      S_DRAIN: begin
        if (redirect_ix_p1) begin
          // The HALT was on the wrong path; resume normal operation
          w_redirect    = 1'b1;
          w_redirect_pc = redirect_target_ix_p1;
          w_flush_ifid  = 1'b1;
          w_flush_idix  = 1'b1;
          w_state_nxt   = S_RUN;
          w_cnt_nxt     = '0;
        end else begin
          w_stall      = 1'b1;
          w_flush_idix = 1'b1;
          w_cnt_nxt    = r_cnt + c_CNT_ONE;
          if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        w_stall      = 1'b1;
        w_flush_idix = 1'b1;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Controls are forced low while reset is held
  assign stall_ifid_p1     = rst & w_stall;
  assign flush_ifid_p1     = rst & w_flush_ifid;
  assign flush_idix_p1     = rst & w_flush_idix;
  assign redirect_valid_p1 = rst & w_redirect;
  assign redirect_pc_p1    = (rst & w_redirect) ? w_redirect_pc : 16'h0000;
  assign epc_p1            = r_epc;
  assign halted_p1         = (r_state == S_HALTED);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Drain counter, pending-load tracking and exception state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_ld_pend_v  <= 1'b0;
      r_ld_pend_rd <= 3'd0;
      r_exc_active <= 1'b0;
      r_epc        <= 16'h0000;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_ld_pend_v  <= w_ld_pend_v_nxt;
      r_ld_pend_rd <= rd_idix_p1;
      r_exc_active <= w_exc_active_nxt;
      r_epc        <= w_epc_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. A driver applies one
//               stimulus per cycle and pushes the reference model's expected
//               outputs into a queue; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam logic [15:0] EXC_V = 16'h0002;
  localparam int          DRAIN = 3;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [15:0] pc;
    logic [2:0]  rs, rt, rd;
    logic        rs_u, rt_u, ld, halt, ill, rti, redir;
    logic [15:0] tgt;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        fifid;
    logic        fidix;
    logic        rv;
    logic [15:0] rpc;
    logic [15:0] epc;
    logic        halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] pc = '0;
  logic [2:0]  rs = '0, rt = '0, rd = '0;
  logic        rs_u = 1'b0, rt_u = 1'b0, ld = 1'b0;
  logic        halt = 1'b0, ill = 1'b0, rti = 1'b0, redir = 1'b0;
  logic [15:0] tgt = '0;
  logic        stall, fifid, fidix, rv, halted;
  logic [15:0] rpc, epc;

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];

  // Reference model state: abstract counters/flags, not the DUT encoding
  int          m_last_ld;     // register written by the previous issued load, -1 if none
  bit          m_exc;
  logic [15:0] m_epc;
  int          m_drain_left;  // cycles of drain still to run, 0 when not draining
  bit          m_halted;

  pipe_ctrl #(.EXC_VECTOR(EXC_V), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst_n),
    .inst_valid_idix_p1(valid), .pc_p1(pc),
    .rs_idix_p1(rs), .rt_idix_p1(rt),
    .rs_used_idix_p1(rs_u), .rt_used_idix_p1(rt_u),
    .rd_idix_p1(rd), .ld_idix_p1(ld),
    .halt_idif_p1(halt), .illegal_op_idif_p1(ill),
    .return_execution_idif_p1(rti),
    .redirect_ix_p1(redir), .redirect_target_ix_p1(tgt),
    .stall_ifid_p1(stall), .flush_ifid_p1(fifid), .flush_idix_p1(fidix),
    .redirect_valid_p1(rv), .redirect_pc_p1(rpc),
    .epc_p1(epc), .halted_p1(halted)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.valid = 1'b0; s.pc = 16'h0; s.rs = 0; s.rt = 0; s.rd = 0;
    s.rs_u = 0; s.rt_u = 0; s.ld = 0; s.halt = 0; s.ill = 0; s.rti = 0;
    s.redir = 0; s.tgt = 16'h0;
    return s;
  endfunction

  function automatic stim_t inst(input logic [15:0] p);
    stim_t s;
    s = idle();
    s.valid = 1'b1;
    s.pc = p;
    return s;
  endfunction

  // Apply one cycle of stimulus, predict the response, advance the model
  task automatic step(input stim_t s);
    exp_t e;
    bit   hz;
    int   nxt_ld;
    @(posedge clk);
    #2;
    rst_n = s.rst_n; valid = s.valid; pc = s.pc; rs = s.rs; rt = s.rt; rd = s.rd;
    rs_u = s.rs_u; rt_u = s.rt_u; ld = s.ld; halt = s.halt; ill = s.ill;
    rti = s.rti; redir = s.redir; tgt = s.tgt;
    e = '0;
    if (!s.rst_n) begin
      m_last_ld = -1; m_exc = 0; m_epc = 16'h0; m_drain_left = 0; m_halted = 0;
    end else begin
      e.epc = m_epc;
      e.halted = m_halted;
      if (m_halted) begin
        e.stall = 1; e.fidix = 1;
      end else if (m_drain_left > 0) begin
        if (s.redir) begin
          e.rv = 1; e.rpc = s.tgt; e.fifid = 1; e.fidix = 1;
          m_drain_left = 0;
        end else begin
          e.stall = 1; e.fidix = 1;
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1;
        end
        m_last_ld = -1;
      end else begin
        hz = s.valid && (m_last_ld >= 0) &&
             ((s.rs_u && int'(s.rs) == m_last_ld) || (s.rt_u && int'(s.rt) == m_last_ld));
        nxt_ld = -1;
        if (s.redir) begin
          e.rv = 1; e.rpc = s.tgt; e.fifid = 1; e.fidix = 1;
        end else if (hz) begin
          e.stall = 1; e.fidix = 1;
        end else if (s.valid) begin
          if (s.ill && !m_exc) begin
            e.rv = 1; e.rpc = EXC_V; e.fifid = 1; e.fidix = 1;
            m_epc = s.pc + 16'd2;
            m_exc = 1;
          end else if (s.ill || (s.halt && !s.rti)) begin
            e.fifid = 1;
            m_drain_left = DRAIN;
          end else if (s.rti) begin
            e.rv = 1; e.rpc = m_epc; e.fifid = 1; e.fidix = 1;
            m_exc = 0;
          end else if (s.ld) begin
            nxt_ld = int'(s.rd);
          end
        end
        m_last_ld = nxt_ld;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare whatever the driver predicted for this cycle
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {stall, fifid, fidix, rv, rpc, epc, halted};
        tests++;
        if (a !== e)
          begin
            fails++;
            $display("FAIL cycle_outputs t=%0t got stall=%b fifid=%b fidix=%b rv=%b rpc=%h epc=%h halted=%b expected stall=%b fifid=%b fidix=%b rv=%b rpc=%h epc=%h halted=%b",
                     $time, a.stall, a.fifid, a.fidix, a.rv, a.rpc, a.epc, a.halted,
                     e.stall, e.fifid, e.fidix, e.rv, e.rpc, e.epc, e.halted);
          end
      end
    end
  end

  initial begin
    stim_t s;
    m_last_ld = -1; m_exc = 0; m_epc = 16'h0; m_drain_left = 0; m_halted = 0;

    // Reset state
    s = idle(); s.rst_n = 1'b0;
    step(s); step(s);
    step(idle());

    // Load-use: load r3 then consumer reading r3 stalls once, then reissues
    s = inst(16'h0010); s.ld = 1; s.rd = 3; step(s);
    s = inst(16'h0012); s.rs = 3; s.rs_u = 1; step(s); step(s);
    s = inst(16'h0014); s.ld = 1; s.rd = 3; step(s);
    s = inst(16'h0016); s.rs = 3; s.rs_u = 0; step(s);
    s = inst(16'h0018); s.ld = 1; s.rd = 5; step(s);
    s = inst(16'h001A); s.rt = 5; s.rt_u = 1; step(s); step(s);

    // Illegal op, RTI sees new EPC immediately; wrap at 0xFFFE
    s = inst(16'h0040); s.ill = 1; step(s);
    s = inst(16'h0002); s.rti = 1; step(s);
    s = inst(16'hFFFE); s.ill = 1; step(s);
    s = inst(16'h0002); s.rti = 1; step(s);
    s = inst(16'h0050); s.rti = 1; step(s);

    // Nested illegal op is fatal: drain, halt, ignore redirect
    s = inst(16'h0060); s.ill = 1; step(s);
    s = inst(16'h0070); s.ill = 1; step(s);
    for (int i = 0; i < 4; i++) step(idle());
    s = idle(); s.redir = 1; s.tgt = 16'h0300; step(s);
    s = idle(); s.rst_n = 1'b0; step(s);
    step(idle());

    // HALT, then a wrong-path redirect in drain cycle 2
    s = inst(16'h0080); s.halt = 1; step(s);
    step(idle());
    s = idle(); s.redir = 1; s.tgt = 16'h0100; step(s);
    for (int i = 0; i < 4; i++) step(inst(16'h0100 + 16'(2 * i)));

    // Execute redirect beats an illegal op in decode
    s = inst(16'h0090); s.ill = 1; s.redir = 1; s.tgt = 16'h0200; step(s);
    s = inst(16'h0200); s.rti = 1; step(s);

    // Reset asserted mid-drain
    s = inst(16'h00A0); s.halt = 1; step(s);
    step(idle());
    s = idle(); s.rst_n = 1'b0; step(s);
    step(idle()); step(idle());

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.valid = ($urandom_range(0, 9) < 8);
      s.pc    = 16'($urandom);
      s.rs    = 3'($urandom_range(0, 3));
      s.rt    = 3'($urandom_range(0, 3));
      s.rd    = 3'($urandom_range(0, 3));
      s.rs_u  = 1'($urandom_range(0, 1));
      s.rt_u  = 1'($urandom_range(0, 1));
      s.ld    = ($urandom_range(0, 2) == 0);
      s.halt  = ($urandom_range(0, 39) == 0);
      s.ill   = ($urandom_range(0, 24) == 0);
      s.rti   = ($urandom_range(0, 14) == 0);
      s.redir = ($urandom_range(0, 9) == 0);
      s.tgt   = 16'($urandom);
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
        s.rst_n = 1'b0;
      step(s);
    end

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drained got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
